// File: rtl/ahb_bus_arbiter_pkg.sv
// ahb_bus_arbiter_pkg: AHB transfer/burst/response codes and arbiter state encoding
package ahb_bus_arbiter_pkg;
  typedef enum logic [1:0] {HT_IDLE = 2'b00, HT_BUSY = 2'b01, HT_NONSEQ = 2'b10, HT_SEQ = 2'b11} htrans_e;
  typedef enum logic [2:0] {
    HB_SINGLE = 3'b000, HB_INCR = 3'b001, HB_WRAP4 = 3'b010, HB_INCR4 = 3'b011,
    HB_WRAP8 = 3'b100, HB_INCR8 = 3'b101, HB_WRAP16 = 3'b110, HB_INCR16 = 3'b111
  } hburst_e;
  typedef enum logic [1:0] {HR_OKAY = 2'b00, HR_ERROR = 2'b01, HR_RETRY = 2'b10, HR_SPLIT = 2'b11} hresp_e;
  typedef enum logic [1:0] {ST_ARB = 2'b00, ST_BURST = 2'b01, ST_LOCK = 2'b10} arb_state_e;
  function automatic logic [3:0] burst_len(input logic [2:0] b);
    return (b == HB_INCR4 || b == HB_WRAP4) ? 4'd3 :
           (b == HB_INCR8 || b == HB_WRAP8) ? 4'd7 :
           (b == HB_INCR16 || b == HB_WRAP16) ? 4'd15 : 4'd0;
  endfunction
endpackage

// File: rtl/ahb_arb_picker.sv
// ahb_arb_picker: combinational fixed-priority / round-robin winner selection
module ahb_arb_picker #(
  parameter int NUM_MASTERS = 4,
  parameter int MW = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [MW-1:0]          ptr,
  input  logic                   rr,
  output logic [NUM_MASTERS-1:0] win_oh,
  output logic [MW-1:0]          win_idx
);
  function automatic int slot(input int k, input logic [MW-1:0] p, input logic r);
    return r ? (int'(p) + k) % NUM_MASTERS : k - 1;
  endfunction
  // scan from lowest to highest priority so the last hit is the winner
  always_comb begin
    win_idx = '0;
    for (int k = NUM_MASTERS; k > 0; k--)
      if (req[slot(k, ptr, rr)]) win_idx = MW'(slot(k, ptr, rr));
    win_oh = |req ? NUM_MASTERS'(1) << win_idx : '0;
  end
endmodule

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: AHB arbiter with burst/lock tracking and registered one-hot grant
module ahb_bus_arbiter
  import ahb_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int MW = 2,
  parameter int DEFAULT_MASTER = 0,
  parameter int RR_EN = 1
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]          HMASTER,
  output logic                   HMASTLOCK
);
  localparam logic [NUM_MASTERS-1:0] DEF_OH = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);
  arb_state_e state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [MW-1:0] ptr, gidx, win_idx, new_idx;
  logic [NUM_MASTERS-1:0] win_oh, grant_nxt;
  logic lock_req, err, last_beat, arb_ok, keep, rr_mode;
  assign rr_mode = RR_EN != 0;
  ahb_arb_picker #(.NUM_MASTERS(NUM_MASTERS), .MW(MW)) u_picker (
    .req(HBUSREQ), .ptr(ptr), .rr(rr_mode), .win_oh(win_oh), .win_idx(win_idx)
  );
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) if (HGRANT[i]) gidx = MW'(i);
  end
  always_comb begin
    lock_req = HLOCK[gidx] & HBUSREQ[gidx];
    err = HRESP != HR_OKAY && !HREADY;
    last_beat = state == ST_BURST && cnt == 4'd1 && HTRANS == HT_SEQ && HREADY;
    arb_ok = !lock_req && state != ST_LOCK && (state == ST_ARB || last_beat || err);
    // an undefined-length INCR owner keeps the bus while it still requests
    keep = HBUSREQ[gidx] && state == ST_ARB && HBURST == HB_INCR && HTRANS[0];
    cnt_nxt = err ? 4'd0 : !HREADY ? cnt : HTRANS == HT_NONSEQ ? burst_len(HBURST) :
              (HTRANS == HT_SEQ && cnt != 4'd0) ? cnt - 4'd1 : cnt;
    state_nxt = lock_req ? ST_LOCK : err ? ST_ARB :
                state == ST_LOCK ? ((!HLOCK[gidx] && HREADY) ? ST_ARB : ST_LOCK) :
                state == ST_ARB ? ((HREADY && HTRANS == HT_NONSEQ && cnt_nxt != 4'd0) ? ST_BURST : ST_ARB) :
                (cnt_nxt == 4'd0 ? ST_ARB : ST_BURST);
    new_idx = |HBUSREQ ? win_idx : DEF_IDX;
    grant_nxt = (!arb_ok || keep) ? HGRANT : |HBUSREQ ? win_oh : DEF_OH;
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= ST_ARB;
      cnt <= 4'd0;
      ptr <= DEF_IDX;
      HGRANT <= DEF_OH;
      HMASTER <= DEF_IDX;
      HMASTLOCK <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      HGRANT <= grant_nxt;
      if (grant_nxt != HGRANT) ptr <= new_idx;
      if (HREADY) begin
        HMASTER <= gidx;
        HMASTLOCK <= HLOCK[gidx];
      end
    end
  end
endmodule
